// File: rtl/alu_pkg.sv
// Shared types for the ALU request issuer: opcode encoding, request payload, FSM states.
package alu_pkg;

    localparam int OPCODE_W = 3;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_LT  = 3'b011
    } alu_op_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic [TAG_W-1:0]    tag;
    } alu_req_t;

    localparam int REQ_W = $bits(alu_req_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_RESP  = 2'b10
    } issuer_state_e;

    function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_LT: op_is_legal = 1'b1;
            default:               op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// In-order request FIFO; not_full is registered so it reads 0 throughout reset.
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 71
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             not_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             not_full_r;
    logic             push_s;
    logic             pop_s;

    // A push is refused when full even if a pop happens in the same cycle.
    assign push_s = push && not_full_r;
    assign pop_s  = pop && (count_r != {CNT_W{1'b0}});

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, wrapping pointers and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            not_full_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r    <= count_nxt_s;
            not_full_r <= (count_nxt_s != CNT_W'(DEPTH));
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign empty    = (count_r == {CNT_W{1'b0}});
    assign not_full = not_full_r;

endmodule

// File: rtl/alu_req_issuer.sv
// Queues ALU requests, drives an external combinational ALU and returns tagged responses.
// Optional build macro ALU_ISSUER_PERF_CNT_EN adds the 16-bit perf_count output.
module alu_req_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OPCODE_W-1:0] req_opcode,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    input  logic [TAG_W-1:0]    req_tag,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OPCODE_W-1:0] alu_opcode,
    input  logic [DATA_W-1:0]   alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                rsp_err
`ifdef ALU_ISSUER_PERF_CNT_EN
    ,
    output logic [15:0]         perf_count
`endif
);

    issuer_state_e       state_r;
    issuer_state_e       state_nxt_s;
    alu_req_t            req_s;
    alu_req_t            head_s;
    logic                fifo_empty_s;
    logic                fifo_not_full_s;
    logic                push_s;
    logic                pop_s;

    logic [DATA_W-1:0]   alu_a_r;
    logic [DATA_W-1:0]   alu_b_r;
    logic [OPCODE_W-1:0] alu_opcode_r;
    logic [TAG_W-1:0]    alu_tag_r;
    logic                rsp_valid_r;
    logic [DATA_W-1:0]   rsp_result_r;
    logic [TAG_W-1:0]    rsp_tag_r;
    logic                rsp_err_r;

    assign req_s  = '{opcode: req_opcode, a: req_a, b: req_b, tag: req_tag};
    assign push_s = req_valid && fifo_not_full_s;

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (req_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .empty     (fifo_empty_s),
        .not_full  (fifo_not_full_s)
    );

    // Next state and FIFO pop; a RESP handshake chains straight into the next DRIVE.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_DRIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ST_DRIVE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ALU operand registers; they keep the last issued request while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r      <= {DATA_W{1'b0}};
            alu_b_r      <= {DATA_W{1'b0}};
            alu_opcode_r <= {OPCODE_W{1'b0}};
            alu_tag_r    <= {TAG_W{1'b0}};
        end else if (pop_s) begin
            alu_a_r      <= head_s.a;
            alu_b_r      <= head_s.b;
            alu_opcode_r <= head_s.opcode;
            alu_tag_r    <= head_s.tag;
        end
    end

    // Response payload captured at the end of DRIVE; illegal opcodes report zero with err set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_r <= {DATA_W{1'b0}};
            rsp_tag_r    <= {TAG_W{1'b0}};
            rsp_err_r    <= 1'b0;
        end else if (state_r == ST_DRIVE) begin
            rsp_tag_r <= alu_tag_r;
            if (op_is_legal(alu_opcode_r)) begin
                rsp_result_r <= alu_result;
                rsp_err_r    <= 1'b0;
            end else begin
                rsp_result_r <= {DATA_W{1'b0}};
                rsp_err_r    <= 1'b1;
            end
        end
    end

    // Registered response valid, mirrors the RESP state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= (state_nxt_s == ST_RESP);
        end
    end

`ifdef ALU_ISSUER_PERF_CNT_EN
    logic [15:0] perf_count_r;

    // Completed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_count_r <= 16'h0000;
        end else if (rsp_valid_r && rsp_ready) begin
            perf_count_r <= perf_count_r + 16'h0001;
        end
    end

    assign perf_count = perf_count_r;
`endif

    assign req_ready  = fifo_not_full_s;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_opcode = alu_opcode_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_tag    = rsp_tag_r;
    assign rsp_err    = rsp_err_r;

endmodule
